uart_bus_input_parser: RTL and testbench

- Receive-side counterpart to the UART bus-debug printer.
- Parses a command typed on the UART into a byte and drives it onto the 6502 data bus for the CPU.
- Command format: CMD_CHAR, two ASCII hex digits, CR. Example: "a3F\r" drives 8'h3F.
- Sits between the UART RX path (rx_data/new_rx_data) and the data-bus mux in front of the CPU. The driven byte is held until the bus side acknowledges it.

---
 rtl/uart_bus_input_parser_if.sv | 25 ++
 rtl/uart_bus_input_parser.sv | 154 +++++++++++++++
 tb/tb_uart_bus_input_parser.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_bus_input_parser_if.sv
// Bus bundle between the UART byte stream, the CPU data-bus mux and the command parser.
// The master side is the parser; the slave side is the surrounding UART/bus logic.
interface uart_bus_input_parser_if;
  logic [7:0] rx_data;
  logic       new_rx_data;
  logic       data_ack;
  logic [7:0] data_out;
  logic       data_oe;
  logic       busy;
  logic       cmd_done;
  logic       cmd_err;
  logic [7:0] tx_data;
  logic       new_tx_data;
  logic       tx_busy;

  modport master (
    input  rx_data, new_rx_data, data_ack, tx_busy,
    output data_out, data_oe, busy, cmd_done, cmd_err, tx_data, new_tx_data
  );

  modport slave (
    output rx_data, new_rx_data, data_ack, tx_busy,
    input  data_out, data_oe, busy, cmd_done, cmd_err, tx_data, new_tx_data
  );
endinterface

// File: rtl/uart_bus_input_parser.sv
// Parses "<CMD_CHAR><hex><hex>\r" from the UART and drives the byte onto the 6502 data bus
// until acknowledged. Optional echo of consumed bytes is enabled by defining CMD_ECHO_EN.
module uart_bus_input_parser #(
  parameter logic [7:0]           CMD_CHAR       = 8'h61,
  parameter int unsigned          TIMEOUT_W      = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = TIMEOUT_W'(10_000_000)
) (
  input  logic                     clk,
  input  logic                     rst,
  uart_bus_input_parser_if.master  bus
);

  localparam logic [7:0]           ESC_CHAR     = 8'h1B;
  localparam logic [7:0]           CR_CHAR      = 8'h0D;
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_CYCLES - TIMEOUT_W'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HI    = 3'd1,
    LO    = 3'd2,
    TERM  = 3'd3,
    DRIVE = 3'd4
  } state_t;

  state_t               state;
  logic [TIMEOUT_W-1:0] tcnt;
  logic [7:0]           nibbles;
  logic                 is_hex;
  logic [3:0]           nib;

  // ASCII hex digit decode of the incoming byte
  always_comb begin
    is_hex = 1'b0;
    nib    = 4'h0;
    if (bus.rx_data >= 8'h30 && bus.rx_data <= 8'h39) begin
      is_hex = 1'b1;
      nib    = 4'(bus.rx_data - 8'h30);
    end else if (bus.rx_data >= 8'h41 && bus.rx_data <= 8'h46) begin
      is_hex = 1'b1;
      nib    = 4'(bus.rx_data - 8'h37);
    end else if (bus.rx_data >= 8'h61 && bus.rx_data <= 8'h66) begin
      is_hex = 1'b1;
      nib    = 4'(bus.rx_data - 8'h57);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      tcnt         <= '0;
      nibbles      <= 8'h00;
      bus.data_out <= 8'h00;
      bus.data_oe  <= 1'b0;
      bus.busy     <= 1'b0;
      bus.cmd_done <= 1'b0;
      bus.cmd_err  <= 1'b0;
    end else begin
      bus.cmd_done <= 1'b0;
      bus.cmd_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.new_rx_data && bus.rx_data == CMD_CHAR) begin
            state    <= HI;
            bus.busy <= 1'b1;
            tcnt     <= '0;
          end
        end
        HI, LO, TERM: begin
          if (bus.new_rx_data) begin
            tcnt <= '0;
            if (state != TERM && is_hex) begin
              if (state == HI) begin
                nibbles[7:4] <= nib;
                state        <= LO;
              end else begin
                nibbles[3:0] <= nib;
                state        <= TERM;
              end
            end else if (state == TERM && bus.rx_data == CR_CHAR) begin
              bus.data_out <= nibbles;
              bus.data_oe  <= 1'b1;
              state        <= DRIVE;
            end else begin
              // ESC abandons quietly; anything else is a malformed command
              state       <= IDLE;
              bus.busy    <= 1'b0;
              bus.cmd_err <= (bus.rx_data != ESC_CHAR);
            end
          end else if (tcnt == TIMEOUT_LAST) begin
            state       <= IDLE;
            bus.busy    <= 1'b0;
            bus.cmd_err <= 1'b1;
          end else begin
            tcnt <= tcnt + TIMEOUT_W'(1);
          end
        end
        DRIVE: begin
          // ack takes priority over any byte arriving in the same cycle
          if (bus.data_ack) begin
            state        <= IDLE;
            bus.busy     <= 1'b0;
            bus.data_oe  <= 1'b0;
            bus.cmd_done <= 1'b1;
          end else if (bus.new_rx_data && bus.rx_data == ESC_CHAR) begin
            state       <= IDLE;
            bus.busy    <= 1'b0;
            bus.data_oe <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          bus.busy    <= 1'b0;
          bus.data_oe <= 1'b0;
        end
      endcase
    end
  end

`ifdef CMD_ECHO_EN
  logic       echo_full;
  logic [7:0] echo_byte;
  logic       rx_consumed;

  assign rx_consumed = bus.new_rx_data && (state != IDLE || bus.rx_data == CMD_CHAR);

  // One-entry echo buffer; bytes arriving while it is full are not echoed
  always_ff @(posedge clk) begin
    if (rst) begin
      echo_full       <= 1'b0;
      echo_byte       <= 8'h00;
      bus.tx_data     <= 8'h00;
      bus.new_tx_data <= 1'b0;
    end else begin
      bus.new_tx_data <= 1'b0;
      if (echo_full && !bus.tx_busy) begin
        bus.tx_data     <= echo_byte;
        bus.new_tx_data <= 1'b1;
        echo_full       <= 1'b0;
      end
      if (rx_consumed && !echo_full) begin
        echo_byte <= bus.rx_data;
        echo_full <= 1'b1;
      end
    end
  end
`else
  logic unused_tx_busy;

  assign unused_tx_busy  = bus.tx_busy;
  assign bus.tx_data     = 8'h00;
  assign bus.new_tx_data = 1'b0;
`endif

endmodule

// File: tb/tb_uart_bus_input_parser.sv
// Randomised and directed bench for uart_bus_input_parser against a character-level model.
// Honours CMD_ECHO_EN when defined for the echo path.
module tb_uart_bus_input_parser;
  localparam int unsigned TO  = 16;
  localparam logic [7:0]  ESC = 8'h1B;
  localparam logic [7:0]  CR  = 8'h0D;
  localparam logic [7:0]  CMD = 8'h61;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_bus_input_parser_if bus ();

  uart_bus_input_parser #(
    .CMD_CHAR      (CMD),
    .TIMEOUT_W     (24),
    .TIMEOUT_CYCLES(24'(TO))
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  bit live = 1'b0;
  bit rand_tx_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int hexval(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
    if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
    return -1;
  endfunction

  // Model: number of command characters collected so far, digits, idle time, drive flag
  int         n = 0;
  logic [3:0] dig [2];
  bit         driving = 1'b0;
  int         idle = 0;
  int         v;
  bit         consumed;
  logic [7:0] m_dout = 8'h00;
  bit         m_oe = 1'b0, m_done = 1'b0, m_err = 1'b0;
  bit         e_full = 1'b0, fill;
  logic [7:0] e_byte = 8'h00, m_tx = 8'h00;
  bit         m_ntx = 1'b0;

  always @(posedge clk) begin
    consumed = bus.new_rx_data && (driving || n > 0 || bus.rx_data == CMD);
    m_done = 1'b0;
    m_err  = 1'b0;
    if (rst) begin
      n = 0; driving = 1'b0; idle = 0; m_oe = 1'b0; m_dout = 8'h00;
    end else if (driving) begin
      if (bus.data_ack) begin
        driving = 1'b0; m_oe = 1'b0; m_done = 1'b1;
      end else if (bus.new_rx_data && bus.rx_data == ESC) begin
        driving = 1'b0; m_oe = 1'b0;
      end
    end else if (n == 0) begin
      if (bus.new_rx_data && bus.rx_data == CMD) begin
        n = 1; idle = 0;
      end
    end else if (bus.new_rx_data) begin
      idle = 0;
      if (n < 3) begin
        v = hexval(bus.rx_data);
        if (v >= 0) begin
          dig[n-1] = 4'(v);
          n++;
        end else begin
          m_err = (bus.rx_data != ESC);
          n = 0;
        end
      end else begin
        if (bus.rx_data == CR) begin
          driving = 1'b1; m_oe = 1'b1; m_dout = {dig[0], dig[1]};
        end else begin
          m_err = (bus.rx_data != ESC);
        end
        n = 0;
      end
    end else begin
      idle++;
      if (idle >= int'(TO)) begin
        m_err = 1'b1; n = 0;
      end
    end
    if (rst) begin
      e_full = 1'b0; m_tx = 8'h00; m_ntx = 1'b0;
    end else begin
      m_ntx = 1'b0;
      fill = consumed && !e_full;
      if (e_full && !bus.tx_busy) begin
        m_tx = e_byte; m_ntx = 1'b1; e_full = 1'b0;
      end
      if (fill) begin
        e_byte = bus.rx_data; e_full = 1'b1;
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(posedge clk) begin
    #1;
    if (live) begin
      chk("data_oe", bus.data_oe, m_oe);
      chk("data_out", bus.data_out, m_dout);
      chk("busy", bus.busy, driving || n > 0);
      chk("cmd_done", bus.cmd_done, m_done);
      chk("cmd_err", bus.cmd_err, m_err);
      chk("done_err_excl", bus.cmd_done && bus.cmd_err, 1'b0);
`ifdef CMD_ECHO_EN
      chk("new_tx_data", bus.new_tx_data, m_ntx);
      if (m_ntx) chk("tx_data", bus.tx_data, m_tx);
`else
      chk("new_tx_data", bus.new_tx_data, 1'b0);
      chk("tx_data", bus.tx_data, 8'h00);
`endif
    end
  end

`ifdef CMD_ECHO_EN
  logic [7:0] echo_q[$];
  always @(posedge clk) begin
    #1;
    if (bus.new_tx_data) echo_q.push_back(bus.tx_data);
  end
`endif

  task automatic cyc(input bit nv, input logic [7:0] b, input bit a);
    @(negedge clk);
    rst             = 1'b0;
    bus.new_rx_data = nv;
    bus.rx_data     = b;
    bus.data_ack    = a;
    bus.tx_busy     = rand_tx_busy ? ($urandom_range(0, 3) == 0) : bus.tx_busy;
  endtask

  task automatic idle_n(input int k);
    repeat (k) cyc(1'b0, 8'($urandom), 1'b0);
  endtask

  task automatic send(input logic [7:0] b);
    cyc(1'b1, b, 1'b0);
  endtask

  task automatic do_rst();
    @(negedge clk);
    rst             = 1'b1;
    bus.new_rx_data = 1'b0;
    bus.data_ack    = 1'b0;
  endtask

  function automatic logic [7:0] hexchar();
    int d;
    d = int'($urandom_range(0, 15));
    if (d < 10) return 8'(48 + d);
    return ($urandom_range(0, 1) == 0) ? 8'(55 + d) : 8'(87 + d);
  endfunction

  logic [7:0] t [4];

  initial begin
    bus.rx_data = 8'h00; bus.new_rx_data = 1'b0; bus.data_ack = 1'b0; bus.tx_busy = 1'b0;
    @(negedge clk);
    live = 1'b1;
    chk("reset_oe", bus.data_oe, 1'b0);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_dout", bus.data_out, 8'h00);

    // "a3F\r" with gaps, ack five cycles after CR
    send(CMD); idle_n(12); send(8'h33); idle_n(12); send(8'h46); idle_n(12); send(CR);
    idle_n(1);
    chk("drive_3f_oe", bus.data_oe, 1'b1);
    chk("drive_3f_dout", bus.data_out, 8'h3F);
    idle_n(3); cyc(1'b0, 8'h00, 1'b1); idle_n(1);
    chk("ack_done", bus.cmd_done, 1'b1);
    chk("ack_oe", bus.data_oe, 1'b0);
    chk("ack_busy", bus.busy, 1'b0);
    chk("ack_dout_held", bus.data_out, 8'h3F);

    // lowercase digits, then printer bytes in IDLE
    send(CMD); send(8'h63); send(8'h37); send(CR); idle_n(1);
    chk("drive_c7_dout", bus.data_out, 8'hC7);
    cyc(1'b0, 8'h00, 1'b1); idle_n(1);
    send(8'h68); send(8'h78); idle_n(1);
    chk("idle_h_busy", bus.busy, 1'b0);
    chk("idle_h_err", bus.cmd_err, 1'b0);

    // bad characters
    send(CMD); send(8'h47); idle_n(1);
    chk("bad_g_err", bus.cmd_err, 1'b1);
    idle_n(1);
    chk("bad_g_err_pulse", bus.cmd_err, 1'b0);
    send(CMD); send(8'h31); send(8'h32); send(8'h5A); idle_n(1);
    chk("bad_z_err", bus.cmd_err, 1'b1);
    chk("bad_z_oe", bus.data_oe, 1'b0);

    // timeout expiry and byte on the expiry cycle
    send(CMD); send(8'h35); idle_n(16);
    chk("to_not_yet", bus.cmd_err, 1'b0);
    idle_n(1);
    chk("to_err", bus.cmd_err, 1'b1);
    chk("to_busy", bus.busy, 1'b0);
    send(CMD); send(8'h35); idle_n(15); send(8'h39); idle_n(1);
    chk("to_byte_wins_err", bus.cmd_err, 1'b0);
    chk("to_byte_wins_busy", bus.busy, 1'b1);
    send(CR); idle_n(1);
    chk("to_byte_wins_dout", bus.data_out, 8'h59);
    cyc(1'b0, 8'h00, 1'b1); idle_n(1);

    // ack collides with a new command byte; then ESC abort in DRIVE
    send(CMD); send(8'h41); send(8'h30); send(CR); idle_n(1);
    chk("drive_a0_dout", bus.data_out, 8'hA0);
    cyc(1'b1, CMD, 1'b1); idle_n(1);
    chk("collide_done", bus.cmd_done, 1'b1);
    idle_n(1);
    chk("collide_dropped", bus.busy, 1'b0);
    send(CMD); send(8'h41); send(8'h30); send(CR); idle_n(2); send(ESC); idle_n(1);
    chk("esc_oe", bus.data_oe, 1'b0);
    chk("esc_done", bus.cmd_done, 1'b0);

    // reset during LO
    send(CMD); send(8'h34); do_rst(); idle_n(1);
    chk("rst_lo_busy", bus.busy, 1'b0);
    chk("rst_lo_dout", bus.data_out, 8'h00);
    chk("rst_lo_oe", bus.data_oe, 1'b0);

`ifdef CMD_ECHO_EN
    echo_q.delete();
    bus.tx_busy = 1'b0;
    send(CMD); idle_n(3); send(8'h33); idle_n(3); send(8'h46); idle_n(3); send(CR); idle_n(4);
    cyc(1'b0, 8'h00, 1'b1); idle_n(3);
    chk("echo_count", echo_q.size(), 4);
    if (echo_q.size() == 4) begin
      chk("echo0", echo_q[0], 8'h61);
      chk("echo1", echo_q[1], 8'h33);
      chk("echo2", echo_q[2], 8'h46);
      chk("echo3", echo_q[3], 8'h0D);
    end
    echo_q.delete();
    bus.tx_busy = 1'b1;
    send(CMD); send(8'h31); idle_n(2);
    bus.tx_busy = 1'b0;
    idle_n(3); send(ESC); idle_n(3);
    chk("echo_busy_count", echo_q.size(), 2);
    if (echo_q.size() == 2) begin
      chk("echo_busy0", echo_q[0], 8'h61);
      chk("echo_busy1", echo_q[1], 8'h1B);
    end
`endif

    // randomised commands with corruption, timeouts, collisions and resets
    rand_tx_busy = 1'b1;
    for (int it = 0; it < 300; it++) begin
      int r;
      if ($urandom_range(0, 9) == 0) begin
        idle_n(int'($urandom_range(0, 3))); send(8'($urandom));
      end
      t[0] = CMD; t[1] = hexchar(); t[2] = hexchar(); t[3] = CR;
      r = int'($urandom_range(0, 19));
      if (r < 4) t[$urandom_range(1, 3)] = (r < 2) ? ESC : 8'($urandom);
      for (int k = 0; k < 4; k++) begin
        idle_n(($urandom_range(0, 15) == 0) ? int'($urandom_range(15, 18))
                                            : int'($urandom_range(0, 4)));
        send(t[k]);
      end
      idle_n(int'($urandom_range(0, 6)));
      case ($urandom_range(0, 4))
        0:       cyc(1'b1, CMD, 1'b1);
        1:       send(ESC);
        2:       cyc(1'b1, ESC, 1'b1);
        default: cyc(1'b0, 8'($urandom), 1'b1);
      endcase
      idle_n(int'($urandom_range(0, 3)));
      if ($urandom_range(0, 29) == 0) do_rst();
    end
    idle_n(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
